vua_vm_exec: RTL and testbench
==============================

// Module: vua_vm_exec
// PURPOSE
//   Execution back-end for the register-VM code emitted by the vua compiler (the
//   "R<d> = op R<a>, R<b>" / store / cjmp stream). Accepts encoded instruction words over
//   a valid/ready handshake, updates an internal register file, and reports branch redirects
//   to the fetch unit. Sits between the instruction fetcher and the debug/trace port.
// PARAMETERS
//   DATA_W   32   register width in bits (two's complement)
//   NREGS    32   register-file depth (5-bit register fields; fields >= NREGS are illegal)
// PORTS
//   clk         in   1        clock
//   rst         in   1        synchronous reset, active-high
//   in_valid    in   1        instruction word valid
//   in_ready    out  1        core can accept a word this cycle
//   in_insn     in   32       [31:26] op, [25:21] d, [20:16] a, [15] imm, [14:0] b-reg[4:0] or simm15
//   br_valid    out  1        one-cycle pulse: taken cjmp, fetcher must redirect
//   br_target   out  15       label index (b field, unsigned)
//   wb_valid    out  1        register write occurred this cycle (trace)
//   wb_reg      out  5        written register
//   wb_data     out  DATA_W   written value
//   err         out  1        sticky: illegal opcode/register seen; cleared only by rst
//   dbg_addr    in   5        asynchronous register-file read address
//   dbg_data    out  DATA_W   R[dbg_addr] (combinational)
// BEHAVIOUR
//   - Reset: all registers 0, FSM=IDLE, in_ready=0 for the reset cycle then 1; br_valid,
//     wb_valid, err=0; br_target, wb_reg, wb_data=0. rst mid-MUL aborts, no writeback.
//   - Operand B = imm ? sign_extend(simm15) : R[b[4:0]]. Truth: value != 0.
//   - Opcodes: 0 MOV d=B (store); 1 ADD d=A+B; 2 SUB d=A-B; 3 MUL d=low DATA_W of A*B;
//     4 NEG d=-A; 5 NOT d=(A==0); 6 EQ d=(A==B); 7 LT d=(A<B signed); 8 CJMP; 9 NOP.
//     Arithmetic wraps modulo 2^DATA_W; no overflow flag. Compare results are 0/1.
//   - CJMP: cond = d[0]; taken when truth(A)==cond; target = b field.
//   - Handshake: word accepted on edge where in_valid & in_ready. in_insn must hold while
//     in_valid & !in_ready.
//   - FSM: IDLE -> IDLE (single-cycle op), -> MUL (op 3, DATA_W-cycle shift-add),
//     -> BRANCH (taken CJMP). MUL: in_ready=0 for DATA_W cycles, writeback on final cycle,
//     then IDLE. BRANCH: br_valid=1, in_ready=0 for exactly one cycle, then IDLE.
//   - Latency: single-cycle op accepted at edge N -> wb_valid/R[d] updated at edge N+1
//     (visible as wb_* in cycle after N). Back-to-back dependent ops are allowed: pending
//     writeback is forwarded to operand A/B reads; no stall.
//   - Not-taken CJMP, NOP: no wb_valid, no stall.
//   - Illegal opcode (>=10) or register field >= NREGS: err set, instruction is a NOP.
//   - Writes to same register from consecutive instructions: later wins.
//   - dbg_data reflects committed register-file state only (no forwarding).
// TESTING
//   1. rst, then ADD R1=R0+imm 5; ADD R2=R1+imm -7 back-to-back -> wb R1=5, then R2=-2 (fwd).
//   2. MOV R3=imm 6; MUL R4=R3*imm -3 -> in_ready low 32 cycles, wb R4=-18, then ready.
//   3. R5=0; CJMP a=R5 cond=0 b=0x12 -> br_valid 1 cycle, br_target=0x12, in_ready low it;
//      same with cond=1 -> no br_valid, next word accepted next cycle.
//   4. R6=0x7FFFFFFF; ADD R6=R6+imm 1 -> 0x80000000; LT R7=R6<R0 -> 1; EQ R8=R7==imm 1 -> 1.
//   5. Opcode 0x3F -> err=1, no wb; subsequent legal ops still execute, err stays 1.
//   6. rst asserted 10 cycles into MUL -> no wb, all registers 0, in_ready=1 after release.

Source files
------------

// File: rtl/vua_vm_exec.sv
`default_nettype none
// ============================================================================
// Module   : vua_vm_exec
// Brief    : Execution back-end for the vua register-VM instruction stream.
//            Single-cycle ALU ops with writeback forwarding, a DATA_W-cycle
//            shift-add multiplier, and one-cycle branch redirect pulses.
// Revision : 1.0 - initial release
// ============================================================================
module vua_vm_exec #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_insn,
  output logic              br_valid,
  output logic [14:0]       br_target,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              err,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [5:0] C_OP_MOV  = 6'd0;
  localparam logic [5:0] C_OP_ADD  = 6'd1;
  localparam logic [5:0] C_OP_SUB  = 6'd2;
  localparam logic [5:0] C_OP_MUL  = 6'd3;
  localparam logic [5:0] C_OP_NEG  = 6'd4;
  localparam logic [5:0] C_OP_NOT  = 6'd5;
  localparam logic [5:0] C_OP_EQ   = 6'd6;
  localparam logic [5:0] C_OP_LT   = 6'd7;
  localparam logic [5:0] C_OP_CJMP = 6'd8;
  localparam logic [5:0] C_OP_NOP  = 6'd9;

  localparam int              CNT_W      = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL    = 2'd1,
    S_BRANCH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Committed register file; the pending writeback lives in r_wb_* for one cycle.
  logic [DATA_W-1:0] r_regs [NREGS];

  logic              r_wb_valid;
  logic [4:0]        r_wb_reg;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_err;
  logic [14:0]       r_br_target;

  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [4:0]        r_mul_rd;

  logic [5:0]        w_op;
  logic [4:0]        w_fd;
  logic [4:0]        w_fa;
  logic              w_imm;
  logic [14:0]       w_fb;
  logic              w_accept;
  logic              w_illegal;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic [DATA_W-1:0] w_result;
  logic              w_single_wr;
  logic              w_taken;
  logic [DATA_W-1:0] w_acc_next;
  logic              w_mul_last;

  assign w_op  = in_insn[31:26];
  assign w_fd  = in_insn[25:21];
  assign w_fa  = in_insn[20:16];
  assign w_imm = in_insn[15];
  assign w_fb  = in_insn[14:0];

  assign w_accept   = in_valid & in_ready;
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last = (r_cnt == C_CNT_LAST);

  // Decode, operand fetch with forwarding of the pending writeback, and ALU.
  always_comb begin
    w_illegal   = 1'b0;
    w_opa       = '0;
    w_opb       = '0;
    w_result    = '0;
    w_single_wr = 1'b0;
    w_taken     = 1'b0;

    if (w_op > C_OP_NOP) begin
      w_illegal = 1'b1;
    end
    if ((int'(w_fd) >= NREGS) || (int'(w_fa) >= NREGS) ||
        (!w_imm && (int'(w_fb[4:0]) >= NREGS))) begin
      w_illegal = 1'b1;
    end

    w_opa = (r_wb_valid && (r_wb_reg == w_fa)) ? r_wb_data : r_regs[w_fa];
    if (w_imm) begin
      w_opb = {{(DATA_W-15){w_fb[14]}}, w_fb};
    end else begin
      w_opb = (r_wb_valid && (r_wb_reg == w_fb[4:0])) ? r_wb_data : r_regs[w_fb[4:0]];
    end

    case (w_op)
      C_OP_MOV: begin w_result = w_opb;                          w_single_wr = 1'b1; end
      C_OP_ADD: begin w_result = w_opa + w_opb;                  w_single_wr = 1'b1; end
      C_OP_SUB: begin w_result = w_opa - w_opb;                  w_single_wr = 1'b1; end
      C_OP_NEG: begin w_result = '0 - w_opa;                     w_single_wr = 1'b1; end
      C_OP_NOT: begin w_result = DATA_W'(w_opa == '0);           w_single_wr = 1'b1; end
      C_OP_EQ:  begin w_result = DATA_W'(w_opa == w_opb);        w_single_wr = 1'b1; end
      C_OP_LT:  begin w_result = DATA_W'($signed(w_opa) < $signed(w_opb)); w_single_wr = 1'b1; end
      default:  begin w_result = '0;                             w_single_wr = 1'b0; end
    endcase

    // Branch is taken when the truth value of A matches the condition bit.
    w_taken = (w_op == C_OP_CJMP) && ((w_opa != '0) == w_fd[0]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and handshake/branch outputs.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    br_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = ~rst;
        if (w_accept && !w_illegal) begin
          if (w_op == C_OP_MUL) begin
            w_next = S_MUL;
          end else if (w_taken) begin
            w_next = S_BRANCH;
          end
        end
      end
      S_MUL: begin
        if (w_mul_last) begin
          w_next = S_IDLE;
        end
      end
      S_BRANCH: begin
        br_valid = 1'b1;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: register-file commit, writeback staging, multiplier, error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wb_valid  <= 1'b0;
      r_wb_reg    <= '0;
      r_wb_data   <= '0;
      r_err       <= 1'b0;
      r_br_target <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mul_rd    <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if (r_wb_valid) begin
        r_regs[r_wb_reg] <= r_wb_data;
      end

      if (w_accept) begin
        if (w_illegal) begin
          r_err <= 1'b1;
        end else if (w_single_wr) begin
          r_wb_valid <= 1'b1;
          r_wb_reg   <= w_fd;
          r_wb_data  <= w_result;
        end else if (w_op == C_OP_MUL) begin
          r_mcand  <= w_opa;
          r_mplier <= w_opb;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_mul_rd <= w_fd;
        end else if (w_taken) begin
          r_br_target <= w_fb;
        end
      end

      if (r_state == S_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (w_mul_last) begin
          r_wb_valid <= 1'b1;
          r_wb_reg   <= r_mul_rd;
          r_wb_data  <= w_acc_next;
        end
      end
    end
  end

  assign wb_valid  = r_wb_valid;
  assign wb_reg    = r_wb_reg;
  assign wb_data   = r_wb_data;
  assign err       = r_err;
  assign br_target = r_br_target;
  assign dbg_data  = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_vua_vm_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_vua_vm_exec
// Brief    : Directed table-driven bench for vua_vm_exec.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vua_vm_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_insn = '0;
  logic        br_valid;
  logic [14:0] br_target;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        err;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int n_tests = 0;
  int n_fail  = 0;

  vua_vm_exec #(.DATA_W(32), .NREGS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_insn   (in_insn),
    .br_valid  (br_valid),
    .br_target (br_target),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .err       (err),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    bit          wb;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          br;
    logic [14:0] tgt;
    bit          rdy;
    bit          er;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc(int op, int d, int a, bit imm, int b);
    return {op[5:0], d[4:0], a[4:0], imm, b[14:0]};
  endfunction

  function automatic vec_t mk(logic [31:0] insn, bit wb, int rd, logic [31:0] data,
                              bit br, int tgt, bit rdy, bit er);
    vec_t v;
    v.insn = insn; v.wb = wb; v.rd = rd[4:0]; v.data = data;
    v.br = br; v.tgt = tgt[14:0]; v.rdy = rdy; v.er = er;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (at negedges) for in_ready, bounded.
  task automatic wait_ready(string name);
    int k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Present one word at a negedge; return at the negedge after its acceptance.
  task automatic issue(logic [31:0] insn);
    wait_ready("issue");
    in_insn  = insn;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] val;
    int lowc;
    bit saw_wb;

    // ---------------- table construction ----------------
    vecs.push_back(mk(enc(1, 1, 0, 1, 5),       1, 1,  32'd5,        0, 0, 1, 0));
    vecs.push_back(mk(enc(1, 2, 1, 1, -7),      1, 2,  32'hFFFFFFFE, 0, 0, 1, 0));
    vecs.push_back(mk(enc(2, 10, 1, 0, 2),      1, 10, 32'd7,        0, 0, 1, 0));
    vecs.push_back(mk(enc(4, 11, 10, 1, 0),     1, 11, 32'hFFFFFFF9, 0, 0, 1, 0));
    vecs.push_back(mk(enc(5, 12, 0, 1, 0),      1, 12, 32'd1,        0, 0, 1, 0));
    vecs.push_back(mk(enc(5, 13, 1, 1, 0),      1, 13, 32'd0,        0, 0, 1, 0));
    vecs.push_back(mk(enc(6, 14, 1, 1, 5),      1, 14, 32'd1,        0, 0, 1, 0));
    vecs.push_back(mk(enc(7, 15, 2, 1, -3),     1, 15, 32'd0,        0, 0, 1, 0));
    vecs.push_back(mk(enc(7, 16, 11, 0, 2),     1, 16, 32'd1,        0, 0, 1, 0));
    vecs.push_back(mk(enc(9, 0, 0, 0, 0),       0, 0,  32'd0,        0, 0, 1, 0));
    vecs.push_back(mk(enc(0, 17, 0, 1, 3),      1, 17, 32'd3,        0, 0, 1, 0));
    vecs.push_back(mk(enc(0, 17, 0, 1, 4),      1, 17, 32'd4,        0, 0, 1, 0));
    vecs.push_back(mk(enc(1, 18, 17, 1, 0),     1, 18, 32'd4,        0, 0, 1, 0));
    vecs.push_back(mk(enc(0, 5, 0, 1, 0),       1, 5,  32'd0,        0, 0, 1, 0));
    vecs.push_back(mk(enc(8, 0, 5, 1, 'h12),    0, 0,  32'd0,        1, 'h12, 0, 0));
    vecs.push_back(mk(enc(8, 1, 5, 1, 'h12),    0, 0,  32'd0,        0, 0, 1, 0));
    vecs.push_back(mk(enc(8, 1, 1, 1, 'h7FFF),  0, 0,  32'd0,        1, 'h7FFF, 0, 0));
    vecs.push_back(mk(enc(0, 6, 0, 1, 8192),    1, 6,  32'd8192,     0, 0, 1, 0));
    val = 32'd8192;
    for (int k = 0; k < 18; k++) begin
      val = val << 1;
      vecs.push_back(mk(enc(1, 6, 6, 0, 6), 1, 6, val, 0, 0, 1, 0));
    end
    vecs.push_back(mk(enc(2, 6, 6, 1, 1),       1, 6,  32'h7FFFFFFF, 0, 0, 1, 0));
    vecs.push_back(mk(enc(1, 6, 6, 1, 1),       1, 6,  32'h80000000, 0, 0, 1, 0));
    vecs.push_back(mk(enc(7, 7, 6, 0, 0),       1, 7,  32'd1,        0, 0, 1, 0));
    vecs.push_back(mk(enc(6, 8, 7, 1, 1),       1, 8,  32'd1,        0, 0, 1, 0));
    vecs.push_back(mk(32'hFC000000,             0, 0,  32'd0,        0, 0, 1, 1));
    vecs.push_back(mk(enc(1, 9, 8, 1, 2),       1, 9,  32'd3,        0, 0, 1, 1));

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", 32'(in_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_br_valid", 32'(br_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wb_reg", 32'(wb_reg), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_br_target", 32'(br_target), 32'd0);

    // ---------------- table-driven vectors ----------------
    foreach (vecs[i]) begin
      issue(vecs[i].insn);
      chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].wb));
      if (vecs[i].wb) begin
        chk($sformatf("v%0d_wb_reg", i), 32'(wb_reg), 32'(vecs[i].rd));
        chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].data);
      end
      chk($sformatf("v%0d_br_valid", i), 32'(br_valid), 32'(vecs[i].br));
      if (vecs[i].br) chk($sformatf("v%0d_br_target", i), 32'(br_target), 32'(vecs[i].tgt));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].er));
    end

    // Branch pulse lasts exactly one cycle.
    issue(enc(8, 0, 0, 1, 'h33));
    chk("br_pulse_on", 32'(br_valid), 32'd1);
    @(negedge clk);
    chk("br_pulse_off", 32'(br_valid), 32'd0);
    chk("br_ready_back", 32'(in_ready), 32'd1);

    // ---------------- multiply: R3=6, R4=R3*-3 ----------------
    issue(enc(0, 3, 0, 1, 6));
    chk("mov_r3", wb_data, 32'd6);
    issue(enc(3, 4, 3, 1, -3));
    lowc = 0;
    saw_wb = 0;
    while (!in_ready && lowc < 100) begin
      if (wb_valid) saw_wb = 1;
      lowc++;
      @(negedge clk);
    end
    chk("mul_ready_low_cycles", 32'(lowc), 32'd32);
    chk("mul_no_early_wb", 32'(saw_wb), 32'd0);
    chk("mul_wb_valid", 32'(wb_valid), 32'd1);
    chk("mul_wb_reg", 32'(wb_reg), 32'd4);
    chk("mul_wb_data", wb_data, 32'hFFFFFFEE);
    dbg_addr = 5'd4;
    #1;
    chk("dbg_uncommitted", dbg_data, 32'd0);
    @(negedge clk);
    chk("dbg_committed", dbg_data, 32'hFFFFFFEE);
    dbg_addr = 5'd6;
    #1;
    chk("dbg_r6", dbg_data, 32'h80000000);

    // ---------------- reset in the middle of a multiply ----------------
    issue(enc(3, 20, 3, 1, 5));
    repeat (9) @(negedge clk);
    chk("mul2_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_ready_low", 32'(in_ready), 32'd0);
    chk("mrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_ready_high", 32'(in_ready), 32'd1);
    begin
      int nz = 0;
      for (int r = 0; r < 32; r++) begin
        dbg_addr = r[4:0];
        #1;
        if (dbg_data !== 32'd0) nz++;
      end
      chk("mrst_regs_zero", 32'(nz), 32'd0);
    end
    saw_wb = 0;
    repeat (40) begin
      @(negedge clk);
      if (wb_valid) saw_wb = 1;
    end
    chk("mrst_no_wb", 32'(saw_wb), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
